link_table: RTL and testbench

Per-core load-linked/store-conditional reservation table for the multicore MIPS datapath, the multi-core successor to the single link register. It holds one link (valid bit, block address, age counter) per core, invalidates links on local stores, remote stores, successful SCs and coherence-bus snoops, and returns a same-cycle pass/fail for every SC. It sits between the cores' data-cache controllers and the coherence bus, with one port set per core.

---
 rtl/link_table.sv | 135 +++++++++++++
 tb/tb_link_table.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/link_table.sv
`default_nettype none
// ============================================================================
// Module   : link_table
// Purpose  : Per-core LL/SC reservation table. One link (valid, block tag,
//            age) per core; links are dropped by local/remote stores,
//            successful SCs, bus snoops, exceptions and an optional timeout.
//            SC pass/fail is resolved combinationally in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module link_table #(
    parameter int NCORES  = 2,
    parameter int ADDR_W  = 32,
    parameter int BLK_OFF = 3,
    parameter int TIMEOUT = 0
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NCORES-1:0]          ll_en,
    input  logic [NCORES-1:0]          sc_req,
    input  logic [NCORES-1:0]          st_en,
    input  logic [NCORES-1:0]          exc_clr,
    input  logic [NCORES*ADDR_W-1:0]   cpu_addr,
    input  logic                       snoop_valid,
    input  logic [ADDR_W-1:0]          snoop_addr,
    input  logic [(NCORES > 1 ? $clog2(NCORES) : 1)-1:0] snoop_src,
    output logic [NCORES-1:0]          sc_ok,
    output logic [NCORES-1:0]          link_valid
);

    localparam int SRC_W = (NCORES > 1) ? $clog2(NCORES) : 1;
    localparam int TAG_W = ADDR_W - BLK_OFF;
    localparam int AGE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [AGE_W-1:0] c_age_one  = 1;
    localparam logic [AGE_W-1:0] c_age_max  = '1;
    localparam logic [AGE_W-1:0] c_age_last = (TIMEOUT > 0) ? AGE_W'(TIMEOUT - 1) : '0;

    // Only the block tag of an address is ever compared, so only it is stored.
    logic [NCORES-1:0] r_valid;
    logic [TAG_W-1:0]  r_tag [NCORES];
    logic [AGE_W-1:0]  r_age [NCORES];

    logic [TAG_W-1:0]  w_cpu_tag [NCORES];
    logic [TAG_W-1:0]  w_snoop_tag;
    logic [NCORES-1:0] w_kill;
    logic [NCORES-1:0] w_pre;
    logic [NCORES-1:0] w_sc_ok;
    logic [NCORES-1:0] w_store_hit;

    // Extract the block tag of every incoming address.
    always_comb begin
        w_snoop_tag = snoop_addr[ADDR_W-1:BLK_OFF];
        for (int i = 0; i < NCORES; i++) begin
            w_cpu_tag[i] = cpu_addr[i*ADDR_W+BLK_OFF +: TAG_W];
        end
    end

    // Offset bits never take part in a match.
    generate
        if (BLK_OFF > 0) begin : g_unused
            logic w_unused;
            always_comb begin
                w_unused = ^snoop_addr[BLK_OFF-1:0];
                for (int i = 0; i < NCORES; i++) begin
                    w_unused = w_unused ^ (^cpu_addr[i*ADDR_W +: BLK_OFF]);
                end
            end
        end
    endgenerate

    // SC arbitration: the bus beats any SC, then the lowest core index wins
    // among same-block SCs; winners and plain stores invalidate remote links.
    always_comb begin
        w_kill      = '0;
        w_pre       = '0;
        w_sc_ok     = '0;
        w_store_hit = '0;
        for (int i = 0; i < NCORES; i++) begin
            w_kill[i] = snoop_valid && (snoop_src != SRC_W'(i)) && (w_snoop_tag == r_tag[i]);
            w_pre[i]  = sc_req[i] && r_valid[i] && (r_tag[i] == w_cpu_tag[i]) && !w_kill[i];
        end
        for (int i = 0; i < NCORES; i++) begin
            w_sc_ok[i] = w_pre[i];
            for (int j = 0; j < i; j++) begin
                if (w_pre[j] && (w_cpu_tag[j] == w_cpu_tag[i])) begin
                    w_sc_ok[i] = 1'b0;
                end
            end
        end
        for (int i = 0; i < NCORES; i++) begin
            for (int j = 0; j < NCORES; j++) begin
                if ((j != i) && (st_en[j] || w_sc_ok[j]) && (r_tag[i] == w_cpu_tag[j])) begin
                    w_store_hit[i] = 1'b1;
                end
            end
        end
    end

    assign sc_ok      = w_sc_ok;
    assign link_valid = r_valid;

    // Link state update in priority order: exception, LL, SC, local store,
    // remote store or snoop, timeout, then ageing of a live link.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_valid <= '0;
            for (int i = 0; i < NCORES; i++) begin
                r_tag[i] <= '0;
                r_age[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCORES; i++) begin
                if (exc_clr[i]) begin
                    r_valid[i] <= 1'b0;
                end else if (ll_en[i]) begin
                    r_valid[i] <= 1'b1;
                    r_tag[i]   <= w_cpu_tag[i];
                    r_age[i]   <= '0;
                end else if (sc_req[i]) begin
                    r_valid[i] <= 1'b0;
                end else if (st_en[i] && (r_tag[i] == w_cpu_tag[i])) begin
                    r_valid[i] <= 1'b0;
                end else if (w_store_hit[i] || w_kill[i]) begin
                    r_valid[i] <= 1'b0;
                end else if ((TIMEOUT != 0) && r_valid[i] && (r_age[i] == c_age_last)) begin
                    r_valid[i] <= 1'b0;
                end else if (r_valid[i] && (r_age[i] != c_age_max)) begin
                    r_age[i] <= r_age[i] + c_age_one;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_link_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_link_table
// Purpose  : Directed vector bench for link_table (NCORES=2, BLK_OFF=3);
//            a second instance with TIMEOUT=4 covers link expiry.
// Revision : 1.0 - initial release
// ============================================================================
module tb_link_table;

    logic        CLK;
    logic        nRST;
    logic [1:0]  ll_en, sc_req, st_en, exc_clr;
    logic [31:0] addr0, addr1;
    logic        snoop_valid;
    logic [31:0] snoop_addr;
    logic [0:0]  snoop_src;
    logic [1:0]  sc_ok, link_valid;
    logic [1:0]  sc_ok_t, link_valid_t;

    int n_checks = 0;
    int n_errors = 0;

    link_table #(.NCORES(2), .ADDR_W(32), .BLK_OFF(3), .TIMEOUT(0)) dut (
        .CLK(CLK), .nRST(nRST), .ll_en(ll_en), .sc_req(sc_req), .st_en(st_en),
        .exc_clr(exc_clr), .cpu_addr({addr1, addr0}), .snoop_valid(snoop_valid),
        .snoop_addr(snoop_addr), .snoop_src(snoop_src), .sc_ok(sc_ok),
        .link_valid(link_valid)
    );

    link_table #(.NCORES(2), .ADDR_W(32), .BLK_OFF(3), .TIMEOUT(4)) dut_t (
        .CLK(CLK), .nRST(nRST), .ll_en(ll_en), .sc_req(sc_req), .st_en(st_en),
        .exc_clr(exc_clr), .cpu_addr({addr1, addr0}), .snoop_valid(snoop_valid),
        .snoop_addr(snoop_addr), .snoop_src(snoop_src), .sc_ok(sc_ok_t),
        .link_valid(link_valid_t)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  ll, sc, st, exc;
        logic [31:0] a0, a1;
        logic        snv;
        logic [31:0] sna;
        logic        sns;
        logic [1:0]  exp_ok;
        logic [1:0]  exp_lv;   // link_valid seen during this vector, before its edge
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] ll, input logic [1:0] sc, input logic [1:0] st,
                         input logic [1:0] exc, input logic [31:0] a0, input logic [31:0] a1,
                         input logic snv, input logic [31:0] sna, input logic sns);
        ll_en = ll; sc_req = sc; st_en = st; exc_clr = exc;
        addr0 = a0; addr1 = a1;
        snoop_valid = snv; snoop_addr = sna; snoop_src = sns;
    endtask

    task automatic idle();
        drive(2'b00, 2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
    endtask

    initial begin
        //            ll     sc     st     exc    a0       a1       snv  sna      sns  ok     lv
        vecs[0]  = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h000, 32'h000, 1'b0, 32'h000, 1'b0, 2'b00, 2'b00};
        vecs[1]  = '{2'b01, 2'b00, 2'b00, 2'b00, 32'h100, 32'h000, 1'b0, 32'h000, 1'b0, 2'b00, 2'b00};
        vecs[2]  = '{2'b00, 2'b01, 2'b00, 2'b00, 32'h104, 32'h000, 1'b0, 32'h000, 1'b0, 2'b01, 2'b01};
        vecs[3]  = '{2'b00, 2'b01, 2'b00, 2'b00, 32'h104, 32'h000, 1'b0, 32'h000, 1'b0, 2'b00, 2'b00};
        vecs[4]  = '{2'b01, 2'b00, 2'b00, 2'b00, 32'h200, 32'h000, 1'b0, 32'h000, 1'b0, 2'b00, 2'b00};
        vecs[5]  = '{2'b00, 2'b00, 2'b10, 2'b00, 32'h000, 32'h200, 1'b0, 32'h000, 1'b0, 2'b00, 2'b01};
        vecs[6]  = '{2'b00, 2'b01, 2'b00, 2'b00, 32'h200, 32'h000, 1'b0, 32'h000, 1'b0, 2'b00, 2'b00};
        vecs[7]  = '{2'b01, 2'b00, 2'b00, 2'b00, 32'h200, 32'h000, 1'b0, 32'h000, 1'b0, 2'b00, 2'b00};
        vecs[8]  = '{2'b00, 2'b00, 2'b10, 2'b00, 32'h000, 32'h208, 1'b0, 32'h000, 1'b0, 2'b00, 2'b01};
        vecs[9]  = '{2'b00, 2'b01, 2'b00, 2'b00, 32'h200, 32'h000, 1'b0, 32'h000, 1'b0, 2'b01, 2'b01};
        vecs[10] = '{2'b11, 2'b00, 2'b00, 2'b00, 32'h300, 32'h300, 1'b0, 32'h000, 1'b0, 2'b00, 2'b00};
        vecs[11] = '{2'b00, 2'b11, 2'b00, 2'b00, 32'h300, 32'h300, 1'b0, 32'h000, 1'b0, 2'b01, 2'b11};
        vecs[12] = '{2'b00, 2'b00, 2'b00, 2'b00, 32'h000, 32'h000, 1'b0, 32'h000, 1'b0, 2'b00, 2'b00};
        vecs[13] = '{2'b10, 2'b00, 2'b00, 2'b00, 32'h000, 32'h400, 1'b0, 32'h000, 1'b0, 2'b00, 2'b00};
        vecs[14] = '{2'b00, 2'b10, 2'b00, 2'b00, 32'h000, 32'h400, 1'b1, 32'h404, 1'b0, 2'b00, 2'b10};
        vecs[15] = '{2'b10, 2'b00, 2'b00, 2'b00, 32'h000, 32'h400, 1'b0, 32'h000, 1'b0, 2'b00, 2'b00};
        vecs[16] = '{2'b00, 2'b10, 2'b00, 2'b00, 32'h000, 32'h400, 1'b1, 32'h404, 1'b1, 2'b10, 2'b10};
        vecs[17] = '{2'b01, 2'b00, 2'b00, 2'b00, 32'h500, 32'h000, 1'b0, 32'h000, 1'b0, 2'b00, 2'b00};
        vecs[18] = '{2'b00, 2'b00, 2'b00, 2'b01, 32'h500, 32'h000, 1'b0, 32'h000, 1'b0, 2'b00, 2'b01};
        vecs[19] = '{2'b00, 2'b01, 2'b00, 2'b00, 32'h500, 32'h000, 1'b0, 32'h000, 1'b0, 2'b00, 2'b00};
        vecs[20] = '{2'b11, 2'b00, 2'b00, 2'b00, 32'h600, 32'h600, 1'b0, 32'h000, 1'b0, 2'b00, 2'b00};
        vecs[21] = '{2'b00, 2'b10, 2'b00, 2'b00, 32'h000, 32'h600, 1'b0, 32'h000, 1'b0, 2'b10, 2'b11};
        vecs[22] = '{2'b00, 2'b01, 2'b00, 2'b00, 32'h600, 32'h000, 1'b0, 32'h000, 1'b0, 2'b00, 2'b00};

        // Reset state
        nRST = 1'b0;
        idle();
        sc_req = 2'b11;
        addr0 = 32'h100; addr1 = 32'h100;
        repeat (2) @(posedge CLK);
        #1;
        check("reset_link_valid", link_valid, 2'b00);
        check("reset_sc_ok", sc_ok, 2'b00);
        @(negedge CLK);
        idle();
        nRST = 1'b1;

        // Table of directed vectors on the non-expiring instance
        for (int k = 0; k < 23; k++) begin
            @(negedge CLK);
            drive(vecs[k].ll, vecs[k].sc, vecs[k].st, vecs[k].exc, vecs[k].a0, vecs[k].a1,
                  vecs[k].snv, vecs[k].sna, vecs[k].sns);
            #1;
            check($sformatf("vec%0d_sc_ok", k), sc_ok, vecs[k].exp_ok);
            check($sformatf("vec%0d_link_valid", k), link_valid, vecs[k].exp_lv);
        end

        // Timeout=4: SC in cycle 4 after the LL edge passes
        @(negedge CLK);
        drive(2'b01, 2'b00, 2'b00, 2'b00, 32'h700, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            if (c == 4) drive(2'b00, 2'b01, 2'b00, 2'b00, 32'h700, 32'h0, 1'b0, 32'h0, 1'b0);
            else idle();
            #1;
            check($sformatf("to_pass_lv_c%0d", c), link_valid_t, 2'b01);
        end
        check("to_pass_sc_ok", sc_ok_t, 2'b01);

        // Timeout=4: SC in cycle 5 fails, link fell after 4 cycles
        @(negedge CLK);
        drive(2'b01, 2'b00, 2'b00, 2'b00, 32'h700, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            idle();
            #1;
            check($sformatf("to_fail_lv_c%0d", c), link_valid_t, 2'b01);
        end
        @(negedge CLK);
        drive(2'b00, 2'b01, 2'b00, 2'b00, 32'h700, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check("to_fail_lv_c5", link_valid_t, 2'b00);
        check("to_fail_sc_ok", sc_ok_t, 2'b00);

        // Asynchronous reset between edges drops the link at once
        @(negedge CLK);
        drive(2'b01, 2'b00, 2'b00, 2'b00, 32'h800, 32'h0, 1'b0, 32'h0, 1'b0);
        @(negedge CLK);
        drive(2'b00, 2'b01, 2'b00, 2'b00, 32'h800, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check("arst_pre_lv", link_valid, 2'b01);
        check("arst_pre_sc_ok", sc_ok, 2'b01);
        #1;
        nRST = 1'b0;
        #1;
        check("arst_lv_cleared", link_valid, 2'b00);
        check("arst_sc_ok_low", sc_ok, 2'b00);
        @(negedge CLK);
        idle();
        nRST = 1'b1;
        @(negedge CLK);
        drive(2'b00, 2'b01, 2'b00, 2'b00, 32'h800, 32'h0, 1'b0, 32'h0, 1'b0);
        #1;
        check("arst_post_sc_ok", sc_ok, 2'b00);
        check("arst_post_lv", link_valid, 2'b00);

        @(negedge CLK);
        idle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
